multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: single-cycle decode plus UMUL step sequencing and MEMC copy.
// Define MEMC_EN to build the MEMC block-copy engine; without it opcode 0000000 is illegal.
//
// state   | meaning
// IDLE    | decode the current instruction combinationally
// MUL_RUN | issue MULSTEP each cycle, write back on the last step
// MC_RD   | MEMC read phase for word mc_idx
// MC_WR   | MEMC write phase for word mc_idx
module multicycle_controller #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32,
    parameter int MEMC_LEN_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      instr,
    input  logic                  zero,
    output logic [1:0]            pc_src,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic [2:0]            ls_src,
    output logic [3:0]            alu_control,
    output logic                  alu_src_1,
    output logic                  alu_src_2,
    output logic                  data_write_en,
    output logic                  reg_write_en,
    output logic                  multi_cy,
    output logic                  pc_en,
    output logic                  mc_phase,
    output logic [MEMC_LEN_W-1:0] mc_idx,
    output logic                  illegal
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
`ifdef MEMC_EN
    localparam logic [1:0] MC_RD   = 2'd2;
    localparam logic [1:0] MC_WR   = 2'd3;
`endif

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_UMUL   = 7'b0110000;
`ifdef MEMC_EN
    localparam logic [6:0] OP_MEMC   = 7'b0000000;
`endif

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    // Down-counter holds remaining MUL_RUN cycles after the current one.
    localparam int              CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             bad;
    logic             taken;
    logic [WIDTH-1:0] unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = instr;

`ifdef MEMC_EN
    logic [MEMC_LEN_W-1:0] mc_n_q, mc_n_d, mc_idx_q, mc_idx_d;
    assign mc_idx = mc_idx_q;
`else
    assign mc_idx = '0;
`endif

    always_comb begin
        pc_src        = 2'b00;
        result_src    = 2'b00;
        imm_src       = 3'b000;
        ls_src        = 3'b000;
        alu_control   = ALU_ADD;
        alu_src_1     = 1'b0;
        alu_src_2     = 1'b0;
        data_write_en = 1'b0;
        reg_write_en  = 1'b0;
        multi_cy      = 1'b0;
        pc_en         = 1'b0;
        mc_phase      = 1'b0;
        illegal       = 1'b0;
        bad           = 1'b0;
        taken         = 1'b0;
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;
`ifdef MEMC_EN
        mc_n_d        = mc_n_q;
        mc_idx_d      = mc_idx_q;
`endif
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    pc_en  = 1'b1;
                    ls_src = funct3;
                    case (opcode)
                        OP_LUI: begin
                            reg_write_en = 1'b1;
                            result_src   = 2'b11;
                            imm_src      = 3'b011;
                        end
                        OP_AUIPC: begin
                            reg_write_en = 1'b1;
                            imm_src      = 3'b011;
                            alu_src_1    = 1'b1;
                            alu_src_2    = 1'b1;
                        end
                        OP_JAL: begin
                            reg_write_en = 1'b1;
                            pc_src       = 2'b01;
                            result_src   = 2'b10;
                            imm_src      = 3'b100;
                        end
                        OP_JALR: begin
                            reg_write_en = 1'b1;
                            pc_src       = 2'b10;
                            result_src   = 2'b10;
                            alu_src_2    = 1'b1;
                            bad          = (funct3 != 3'b000);
                        end
                        OP_BRANCH: begin
                            imm_src = 3'b010;
                            case (funct3)
                                3'b000: begin alu_control = ALU_SUB;  taken = zero;  end
                                3'b001: begin alu_control = ALU_SUB;  taken = !zero; end
                                3'b100: begin alu_control = ALU_SLT;  taken = !zero; end
                                3'b101: begin alu_control = ALU_SUB;  taken = zero;  end
                                3'b110: begin alu_control = ALU_SLTU; taken = !zero; end
                                3'b111: begin alu_control = ALU_SUB;  taken = zero;  end
                                default: bad = 1'b1;
                            endcase
                            pc_src = taken ? 2'b01 : 2'b00;
                        end
                        OP_LOAD: begin
                            reg_write_en = 1'b1;
                            result_src   = 2'b01;
                            alu_src_2    = 1'b1;
                            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                        end
                        OP_STORE: begin
                            data_write_en = 1'b1;
                            imm_src       = 3'b001;
                            alu_src_2     = 1'b1;
                            bad           = (funct3 > 3'b010);
                        end
                        OP_IMM: begin
                            reg_write_en = 1'b1;
                            alu_src_2    = 1'b1;
                            case (funct3)
                                3'b000: alu_control = ALU_ADD;
                                3'b010: alu_control = ALU_SLT;
                                3'b011: alu_control = ALU_SLTU;
                                3'b100: alu_control = ALU_XOR;
                                3'b110: alu_control = ALU_OR;
                                3'b111: alu_control = ALU_AND;
                                3'b001: begin
                                    alu_control = ALU_SLL;
                                    bad         = (funct7 != 7'b0000000);
                                end
                                default: begin
                                    alu_control = instr[30] ? ALU_SRA : ALU_SRL;
                                    bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                                end
                            endcase
                        end
                        OP_REG: begin
                            reg_write_en = 1'b1;
                            case ({funct7, funct3})
                                10'b0000000_000: alu_control = ALU_ADD;
                                10'b0100000_000: alu_control = ALU_SUB;
                                10'b0000000_001: alu_control = ALU_SLL;
                                10'b0000000_010: alu_control = ALU_SLT;
                                10'b0000000_011: alu_control = ALU_SLTU;
                                10'b0000000_100: alu_control = ALU_XOR;
                                10'b0000000_101: alu_control = ALU_SRL;
                                10'b0100000_101: alu_control = ALU_SRA;
                                10'b0000000_110: alu_control = ALU_OR;
                                10'b0000000_111: alu_control = ALU_AND;
                                default:         bad = 1'b1;
                            endcase
                        end
                        OP_FENCE: ;
                        OP_UMUL: begin
                            multi_cy    = 1'b1;
                            pc_en       = 1'b0;
                            alu_control = ALU_MUL;
                            state_d     = MUL_RUN;
                            mul_cnt_d   = MUL_LOAD;
                        end
`ifdef MEMC_EN
                        OP_MEMC: begin
                            multi_cy = 1'b1;
                            mc_n_d   = instr[MEMC_LEN_W+19:20];
                            mc_idx_d = '0;
                            if (instr[MEMC_LEN_W+19:20] != '0) begin
                                pc_en   = 1'b0;
                                state_d = MC_RD;
                            end
                        end
`endif
                        default: bad = 1'b1;
                    endcase
                    // Illegal encodings become a harmless PC+4 with no side effects.
                    if (bad) begin
                        pc_src        = 2'b00;
                        result_src    = 2'b00;
                        imm_src       = 3'b000;
                        alu_control   = ALU_ADD;
                        alu_src_1     = 1'b0;
                        alu_src_2     = 1'b0;
                        data_write_en = 1'b0;
                        reg_write_en  = 1'b0;
                        multi_cy      = 1'b0;
                        pc_en         = 1'b1;
                        illegal       = 1'b1;
                        state_d       = IDLE;
                    end
                end
                MUL_RUN: begin
                    multi_cy    = 1'b1;
                    alu_control = ALU_MUL;
                    if (mul_cnt_q == '0) begin
                        reg_write_en = 1'b1;
                        pc_en        = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        mul_cnt_d = mul_cnt_q - 1'b1;
                    end
                end
`ifdef MEMC_EN
                MC_RD: begin
                    multi_cy = 1'b1;
                    state_d  = MC_WR;
                end
                MC_WR: begin
                    multi_cy      = 1'b1;
                    mc_phase      = 1'b1;
                    data_write_en = 1'b1;
                    if (mc_idx_q == mc_n_q - 1'b1) begin
                        pc_en    = 1'b1;
                        mc_idx_d = '0;
                        state_d  = IDLE;
                    end else begin
                        mc_idx_d = mc_idx_q + 1'b1;
                        state_d  = MC_RD;
                    end
                end
`endif
                default: begin
                    multi_cy = 1'b1;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mul_cnt_q <= '0;
`ifdef MEMC_EN
            mc_n_q    <= '0;
            mc_idx_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
`ifdef MEMC_EN
            mc_n_q    <= mc_n_d;
            mc_idx_q  <= mc_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected output vectors are queued per driven cycle.
module tb_multicycle_controller;

    localparam logic [7:0] F_A1  = 8'h80;
    localparam logic [7:0] F_A2  = 8'h40;
    localparam logic [7:0] F_DWE = 8'h20;
    localparam logic [7:0] F_RWE = 8'h10;
    localparam logic [7:0] F_MCY = 8'h08;
    localparam logic [7:0] F_PCE = 8'h04;
    localparam logic [7:0] F_PH  = 8'h02;
    localparam logic [7:0] F_ILL = 8'h01;

    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_JUNK = 32'h0000007F;
    localparam logic [31:0] I_BEQ  = 32'h00418463;
    localparam logic [31:0] I_UMUL = 32'h002081B0;
    localparam logic [31:0] I_MEMC = 32'h00810A00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = I_ADDI;
    logic        zero = 1'b0;
    logic [1:0]  pc_src, result_src;
    logic [2:0]  imm_src, ls_src;
    logic [3:0]  alu_control;
    logic        alu_src_1, alu_src_2, data_write_en, reg_write_en, multi_cy, pc_en, mc_phase, illegal;
    logic [11:0] mc_idx;
    logic [33:0] obs, got, e;

    typedef struct {
        logic [31:0] i;
        logic        z;
        logic [33:0] e;
    } vec_t;

    logic [33:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    multicycle_controller #(.WIDTH(32), .MUL_CYCLES(32), .MEMC_LEN_W(12)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pc_src(pc_src), .result_src(result_src), .imm_src(imm_src), .ls_src(ls_src),
        .alu_control(alu_control), .alu_src_1(alu_src_1), .alu_src_2(alu_src_2),
        .data_write_en(data_write_en), .reg_write_en(reg_write_en), .multi_cy(multi_cy),
        .pc_en(pc_en), .mc_phase(mc_phase), .mc_idx(mc_idx), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {pc_src, result_src, imm_src, ls_src, alu_control,
                  alu_src_1, alu_src_2, data_write_en, reg_write_en,
                  multi_cy, pc_en, mc_phase, illegal, mc_idx};

    function automatic logic [33:0] mk(input logic [1:0] ps, input logic [1:0] rs,
                                       input logic [2:0] is, input logic [2:0] ls,
                                       input logic [3:0] alu, input logic [7:0] fl,
                                       input logic [11:0] idx);
        return {ps, rs, is, ls, alu, fl, idx};
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue what it should produce.
    task automatic drive(input logic [31:0] i, input logic z, input logic [33:0] ex);
        @(posedge clk);
        #1;
        instr = i;
        zero  = z;
        exp_q.push_back(ex);
    endtask

    task automatic test_reset();
        #2;
        exp_q.push_back('0);
        got = obs; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_mis++; $display("FAIL reset_async got=%h want=%h", got, e); end
        @(negedge clk);
        exp_q.push_back('0);
        got = obs; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_mis++; $display("FAIL reset_held got=%h want=%h", got, e); end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        vec_t v[$];
        v.push_back('{I_BEQ,        1'b1, mk(2'b01, 2'b00, 3'b010, 3'b000, 4'b0001, F_PCE, 0)});
        v.push_back('{I_BEQ,        1'b0, mk(2'b00, 2'b00, 3'b010, 3'b000, 4'b0001, F_PCE, 0)});
        v.push_back('{32'h00419463, 1'b0, mk(2'b01, 2'b00, 3'b010, 3'b001, 4'b0001, F_PCE, 0)});
        v.push_back('{32'h00419463, 1'b1, mk(2'b00, 2'b00, 3'b010, 3'b001, 4'b0001, F_PCE, 0)});
        v.push_back('{32'h0041C463, 1'b0, mk(2'b01, 2'b00, 3'b010, 3'b100, 4'b1000, F_PCE, 0)});
        v.push_back('{32'h0041C463, 1'b1, mk(2'b00, 2'b00, 3'b010, 3'b100, 4'b1000, F_PCE, 0)});
        v.push_back('{32'h0041F463, 1'b1, mk(2'b01, 2'b00, 3'b010, 3'b111, 4'b0001, F_PCE, 0)});
        v.push_back('{32'h00232433, 1'b0, mk(2'b00, 2'b00, 3'b000, 3'b010, 4'b1000, F_RWE | F_PCE, 0)});
        v.push_back('{32'h00232BB7, 1'b0, mk(2'b00, 2'b11, 3'b011, 3'b010, 4'b0000, F_RWE | F_PCE, 0)});
        v.push_back('{32'h402081B3, 1'b0, mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0001, F_RWE | F_PCE, 0)});
        v.push_back('{32'h008000EF, 1'b0, mk(2'b01, 2'b10, 3'b100, 3'b000, 4'b0000, F_RWE | F_PCE, 0)});
        v.push_back('{32'h000080E7, 1'b1, mk(2'b10, 2'b10, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0)});
        v.push_back('{32'h0040A103, 1'b0, mk(2'b00, 2'b01, 3'b000, 3'b010, 4'b0000, F_A2 | F_RWE | F_PCE, 0)});
        v.push_back('{32'h0020A223, 1'b0, mk(2'b00, 2'b00, 3'b001, 3'b010, 4'b0000, F_A2 | F_DWE | F_PCE, 0)});
        v.push_back('{32'h4030D093, 1'b0, mk(2'b00, 2'b00, 3'b000, 3'b101, 4'b0111, F_A2 | F_RWE | F_PCE, 0)});
        v.push_back('{32'h00001517, 1'b0, mk(2'b00, 2'b00, 3'b011, 3'b001, 4'b0000, F_A1 | F_A2 | F_RWE | F_PCE, 0)});
        v.push_back('{I_JUNK,       1'b1, mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_ILL | F_PCE, 0)});
        v.push_back('{32'h02000033, 1'b0, mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_ILL | F_PCE, 0)});
        v.push_back('{I_ADDI,       1'b0, mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0)});
        for (int k = 0; k < v.size(); k++) begin
            drive(v[k].i, v[k].z, v[k].e);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin
                n_mis++;
                $display("FAIL decode[%0d] instr=%h got=%h want=%h", k, v[k].i, got, e);
            end
        end
    endtask

    task automatic test_umul();
        logic [33:0] ex;
        for (int c = 0; c < 33; c++) begin
            if (c == 0)       ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b1010, F_MCY, 0);
            else if (c < 31)  ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b1010, F_MCY, 0);
            else if (c == 31) ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b1010, F_MCY | F_RWE | F_PCE, 0);
            else              ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0);
            drive(c == 0 ? I_UMUL : (c == 32 ? I_ADDI : I_JUNK), c[0], ex);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL umul cyc=%0d got=%h want=%h", c + 1, got, e); end
        end
    endtask

    task automatic test_reset_abort_umul();
        for (int c = 0; c < 5; c++) begin
            drive(c == 0 ? I_UMUL : I_JUNK, 1'b0,
                  mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b1010, F_MCY, 0));
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL umul_pre_rst cyc=%0d got=%h want=%h", c + 1, got, e); end
        end
        #1 rst = 1'b1;
        exp_q.push_back('0);
        #1;
        got = obs; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_mis++; $display("FAIL umul_rst_async got=%h want=%h", got, e); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            drive(c == 29 ? I_ADDI : I_BEQ, 1'b0,
                  c == 29 ? mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0)
                          : mk(2'b00, 2'b00, 3'b010, 3'b000, 4'b0001, F_PCE, 0));
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL umul_post_rst cyc=%0d got=%h want=%h", c, got, e); end
        end
    endtask

`ifdef MEMC_EN
    task automatic test_memc();
        logic [33:0] ex;
        int          n_dwe;
        n_dwe = 0;
        for (int c = 0; c < 18; c++) begin
            if (c == 0)
                ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY, 0);
            else if (c == 17)
                ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0);
            else if (c[0])
                ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY, 12'((c - 1) / 2));
            else
                ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000,
                        F_MCY | F_PH | F_DWE | (c == 16 ? F_PCE : 8'h00), 12'((c - 1) / 2));
            drive(c == 0 ? I_MEMC : (c == 17 ? I_ADDI : I_JUNK), c[1], ex);
            @(negedge clk);
            if (data_write_en === 1'b1) n_dwe++;
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL memc cyc=%0d got=%h want=%h", c + 1, got, e); end
        end
        n_cmp++;
        if (n_dwe !== 8) begin n_mis++; $display("FAIL memc_dwe_count got=%0d want=8", n_dwe); end
        for (int c = 0; c < 2; c++) begin
            drive(c == 0 ? 32'h00000A00 : I_ADDI, 1'b0,
                  c == 0 ? mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY | F_PCE, 0)
                         : mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0));
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL memc_zero cyc=%0d got=%h want=%h", c + 1, got, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] ex;
        for (int c = 0; c < 6; c++) begin
            case (c % 3)
                0:       ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY, 0);
                1:       ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY, 0);
                default: ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY | F_PH | F_DWE | F_PCE, 0);
            endcase
            drive((c % 3) == 0 ? 32'h00100000 : I_JUNK, 1'b0, ex);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL b2b_memc1 cyc=%0d got=%h want=%h", c + 1, got, e); end
        end
    endtask

    task automatic test_reset_abort_memc();
        logic [33:0] ex;
        for (int c = 0; c < 6; c++) begin
            if (c == 0)     ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY, 0);
            else if (c[0])  ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY, 12'((c - 1) / 2));
            else            ex = mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_MCY | F_PH | F_DWE, 12'((c - 1) / 2));
            drive(c == 0 ? I_MEMC : I_JUNK, 1'b0, ex);
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL memc_pre_rst cyc=%0d got=%h want=%h", c + 1, got, e); end
        end
        #1 rst = 1'b1;
        exp_q.push_back('0);
        #1;
        got = obs; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_mis++; $display("FAIL memc_rst_async got=%h want=%h", got, e); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(c == 11 ? I_ADDI : I_BEQ, 1'b0,
                  c == 11 ? mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0)
                          : mk(2'b00, 2'b00, 3'b010, 3'b000, 4'b0001, F_PCE, 0));
            @(negedge clk);
            got = obs; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_mis++; $display("FAIL memc_post_rst cyc=%0d got=%h want=%h", c, got, e); end
        end
    endtask
`else
    task automatic test_memc_disabled();
        drive(I_MEMC, 1'b0, mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_ILL | F_PCE, 0));
        @(negedge clk);
        got = obs; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_mis++; $display("FAIL memc_disabled got=%h want=%h", got, e); end
        drive(I_ADDI, 1'b0, mk(2'b00, 2'b00, 3'b000, 3'b000, 4'b0000, F_A2 | F_RWE | F_PCE, 0));
        @(negedge clk);
        got = obs; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_mis++; $display("FAIL memc_disabled_next got=%h want=%h", got, e); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_umul();
        test_reset_abort_umul();
`ifdef MEMC_EN
        test_memc();
        test_back_to_back();
        test_reset_abort_memc();
`else
        test_memc_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
